// File: rtl/prog_rom_bridge_pkg.sv
// Shared widths, timing constants and FSM encoding for the program-ROM bridge.
// Pure definitions: no latency and no flow control.
package prog_rom_bridge_pkg;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int REL_CNT = 8;

    localparam logic [7:0] NOP_BYTE = 8'h00;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_SCAN = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

endpackage

// File: rtl/prog_rom_bridge_if.sv
// Core-side PC/instruction bus plus loader write channel of the program-ROM bridge.
// master = bridge, slave = core and loader; ld_ready gates ld_valid, no other backpressure.
interface prog_rom_bridge_if #(
    parameter int ADDR_W = prog_rom_bridge_pkg::ADDR_W,
    parameter int DATA_W = prog_rom_bridge_pkg::DATA_W
);
    localparam int HALF_W = ADDR_W / 2;

    logic [HALF_W-1:0] pc_hl;
    logic              pc_mux;
    logic [DATA_W-1:0] rom_data;
    logic              core_rst_n;

    logic              ld_mode;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] ld_sum;
    logic [ADDR_W-1:0] cur_addr;

    modport master (
        input  pc_hl, ld_mode, ld_valid, ld_addr, ld_data,
        output pc_mux, rom_data, core_rst_n, ld_ready, ld_sum, cur_addr
    );

    modport slave (
        output pc_hl, ld_mode, ld_valid, ld_addr, ld_data,
        input  pc_mux, rom_data, core_rst_n, ld_ready, ld_sum, cur_addr
    );

endinterface

// File: rtl/prog_store.sv
// Program store: one synchronous write port, one registered read port, contents not reset.
// Read latency 1 clk; read-during-write to the same address returns the old byte; no backpressure.
module prog_store #(
    parameter int ADDR_W = prog_rom_bridge_pkg::ADDR_W,
    parameter int DATA_W = prog_rom_bridge_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_dat_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        rd_q <= mem_q[rd_addr_i];
    end

    assign rd_dat_o = rd_q;

endmodule

// File: rtl/prog_rom_bridge.sv
// Feeds a core from a loadable program store by scanning its multiplexed PC halves.
// PC-to-byte latency up to 5 clk; loader writes accepted only while in LOAD with ld_mode high.
module prog_rom_bridge #(
    parameter int ADDR_W  = prog_rom_bridge_pkg::ADDR_W,
    parameter int DATA_W  = prog_rom_bridge_pkg::DATA_W,
    parameter int REL_CNT = prog_rom_bridge_pkg::REL_CNT
) (
    input  logic              clk,
    input  logic              RESET,
    prog_rom_bridge_if.master bus
);
    import prog_rom_bridge_pkg::*;

    localparam int HALF_W = ADDR_W / 2;
    localparam int CNT_W  = $clog2(REL_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REL_CNT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        phase_q, phase_d;
    logic [HALF_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] sum_q, sum_d;

    logic [DATA_W-1:0] rd_dat;
    logic              in_scan;
    logic              ld_rdy;
    logic              wr_en;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // ld_mode overrides everything so a loader can always seize the core.
    always_comb begin
        state_d = state_q;
        if (bus.ld_mode) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_HOLD: if (cnt_q == CNT_LAST) state_d = ST_SCAN;
                ST_SCAN: state_d = ST_SCAN;
                ST_LOAD: state_d = ST_HOLD;
                default: state_d = ST_HOLD;
            endcase
        end
    end

    always_comb begin
        in_scan = (state_q == ST_SCAN);
        ld_rdy  = (state_q == ST_LOAD) && bus.ld_mode;
        wr_en   = ld_rdy && bus.ld_valid;

        bus.pc_mux     = in_scan && phase_q[1];
        bus.core_rst_n = in_scan;
        bus.ld_ready   = ld_rdy;
        bus.rom_data   = in_scan ? rd_dat : DATA_W'(NOP_BYTE);
        bus.ld_sum     = sum_q;
        bus.cur_addr   = cur_addr_q;
    end

    always_comb begin
        cnt_d      = '0;
        phase_d    = '0;
        lo_d       = lo_q;
        cur_addr_d = cur_addr_q;
        sum_d      = sum_q;

        case (state_q)
            ST_HOLD: begin
                if (state_d == ST_HOLD) cnt_d = cnt_q + CNT_W'(1);
                lo_d       = '0;
                cur_addr_d = '0;
            end
            ST_SCAN: begin
                if (state_d == ST_SCAN) phase_d = phase_q + 2'd1;
                if (phase_q == 2'd1) lo_d = bus.pc_hl;
                if (phase_q == 2'd3) cur_addr_d = {bus.pc_hl, lo_q};
            end
            default: ;
        endcase

        if (wr_en) sum_d = sum_q + bus.ld_data;
        if (state_d == ST_LOAD && state_q != ST_LOAD) sum_d = '0;
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            cnt_q      <= '0;
            phase_q    <= '0;
            lo_q       <= '0;
            cur_addr_q <= '0;
            sum_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            lo_q       <= lo_d;
            cur_addr_q <= cur_addr_d;
            sum_q      <= sum_d;
        end
    end

    // Read port follows cur_addr every clk, so the byte lands one clk after each update.
    prog_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (bus.ld_addr),
        .wr_dat_i  (bus.ld_data),
        .rd_addr_i (cur_addr_q),
        .rd_dat_o  (rd_dat)
    );

endmodule

// File: doc/prog_rom_bridge.md
PROG_ROM_BRIDGE -- requirements
Module: prog_rom_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, program address width ({PU,PL}).
REQ-002 SHALL have parameter DATA_W, default 8, instruction byte width.
REQ-003 SHALL have parameter REL_CNT, default 8, clk cycles that core reset is held after leaving load/reset.
REQ-004 clk  in  1  system clock, same clock as the core.
REQ-005 RESET  in  1  reset, asynchronous, active-low.
REQ-006 pc_hl  in  5  multiplexed PC half from core: PL[4:0] when pc_mux=0, {PU,PL[5]} when pc_mux=1.
REQ-007 pc_mux  out  1  half select driven to core.
REQ-008 rom_data  out  8  instruction byte to core instruction input.
REQ-009 core_rst_n  out  1  active-low reset to core.
REQ-010 ld_mode  in  1  1 = program-load mode.
REQ-011 ld_valid  in  1  load write request.
REQ-012 ld_ready  out  1  bridge accepts a load write.
REQ-013 ld_addr  in  10  load write address.
REQ-014 ld_data  in  8  load write byte.
REQ-015 ld_sum  out  8  modulo-256 sum of bytes accepted in current load session.
REQ-016 cur_addr  out  10  last assembled fetch address.

Function
REQ-017 States: HOLD, SCAN, LOAD; HOLD entered on reset.
REQ-018 HOLD: core_rst_n=0, counter counts REL_CNT clk; then SCAN if ld_mode=0, else LOAD.
REQ-019 SCAN: core_rst_n=1, 2-bit phase counter from 0, wraps 3->0 every clk.
REQ-020 Phase 0: pc_mux=0; phase 1: pc_mux=0, capture pc_hl as low half; phase 2: pc_mux=1; phase 3: pc_mux=1, capture pc_hl as high half and update cur_addr={high,low} = {PU,PL}.
REQ-021 rom_data SHALL be store[cur_addr], registered, valid 1 clk after cur_addr update; worst-case PC-change-to-rom_data latency 5 clk.
REQ-022 rom_data SHALL read 0x00 (NOP) in HOLD and LOAD.
REQ-023 ld_mode=1 in any state SHALL enter LOAD on the next clk, aborting scan mid-phase; core_rst_n=0 on that same edge.
REQ-024 LOAD: ld_ready=1; each clk with ld_valid&ld_ready writes store[ld_addr]=ld_data and adds ld_data to ld_sum (wrap mod 256).
REQ-025 ld_sum SHALL clear on entry to LOAD; holds value after exit.
REQ-026 ld_mode=0 in LOAD SHALL go to HOLD; a write with ld_valid on the exit cycle is not accepted (ld_ready=0 outside LOAD).
REQ-027 Scan after HOLD SHALL restart at phase 0 with cur_addr=0.
REQ-028 Duplicate ld_addr writes: last write wins; ld_sum counts both.
REQ-029 Store contents are not reset; unloaded locations read undefined.

Reset
REQ-030 During RESET=0: state=HOLD, pc_mux=0, rom_data=0x00, core_rst_n=0, ld_ready=0, ld_sum=0, cur_addr=0, phase=0, counter=0.
REQ-031 RESET deassertion SHALL count REL_CNT clk in HOLD before core_rst_n rises.
REQ-032 RESET mid-load SHALL discard the in-flight write; prior writes retained.

Structure
REQ-033 Shared package holds ADDR_W, DATA_W, REL_CNT, NOP byte 0x00, state enum.
REQ-034 One sub-module prog_store: 1024x8, synchronous write port, synchronous read port.

Verification
REQ-035 Reset, ld_mode=0 -> core_rst_n low exactly 8 clk after RESET rise, rom_data=0x00 throughout.
REQ-036 Load 0x80@0x000, 0xC3@0x3FF, 0x0C@0x155 -> ld_sum=0x4F; exit, pc_hl holds 0 both halves -> rom_data=0x80.
REQ-037 Core model presents PC 0x3FF (low 0x1F, high 0x1F) -> cur_addr=0x3FF, rom_data=0xC3 within 5 clk.
REQ-038 PC changes 0x155->0x000 at phase 2 -> one cycle of mixed address allowed, correct 0x080 byte by following phase 3+1.
REQ-039 ld_mode asserted at phase 1 of scan -> next clk core_rst_n=0, ld_ready=1, rom_data=0x00.
REQ-040 ld_valid on exit cycle with ld_addr 0x010 -> store[0x010] unchanged, ld_sum unchanged.
